flow_topk2_index: RTL

- Streaming arg-extreme finder for framed sample streams. Each frame is delimited by din_tlast.
- Per frame, reports the best sample value, its index, the second-best index and the sample count.
- Compare mode (max/min) and signedness are set by parameters; comparison is native integer, with no external compare IP.
- Sits after per-frame metric stages (correlation/energy) and feeds peak-select/decision logic.

---
 rtl/flow_topk2_index.sv | 126 ++++++++++++
 1 files changed

// File: rtl/flow_topk2_index.sv
// rtl/flow_topk2_index.sv - streaming per-frame arg-extreme finder with second-best index
module flow_topk2_index #(
  parameter int DATAWIDTH = 64,
  parameter int AWIDTH    = 8,
  parameter int MODE      = 0,
  parameter int SIGNED    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATAWIDTH-1:0] din,
  input  logic                 din_tvalid,
  input  logic                 din_tlast,
  output logic [DATAWIDTH-1:0] dout_value,
  output logic [AWIDTH-1:0]    dout,
  output logic [AWIDTH-1:0]    dout_second,
  output logic                 dout_second_valid,
  output logic [AWIDTH:0]      dout_count,
  output logic                 dout_ovf,
  output logic                 dout_tvalid
);

  localparam int CW = AWIDTH + 1;
  localparam logic [CW-1:0] CNT_MAX = '1;

  function automatic logic better(input logic [DATAWIDTH-1:0] a, input logic [DATAWIDTH-1:0] b);
    logic gt;
    logic lt;
    if (SIGNED != 0) begin
      gt = $signed(a) > $signed(b);
      lt = $signed(a) < $signed(b);
    end else begin
      gt = a > b;
      lt = a < b;
    end
    return (MODE == 0) ? gt : lt;
  endfunction

  logic [DATAWIDTH-1:0] best_val, sec_val, nxt_best_val, nxt_sec_val;
  logic [AWIDTH-1:0]    best_idx, sec_idx, nxt_best_idx, nxt_sec_idx;
  logic                 sec_vld, nxt_sec_vld;
  logic [CW-1:0]        cnt, nxt_cnt;
  logic                 ovf, nxt_ovf;
  logic [AWIDTH-1:0]    idx;

  // cnt doubles as the index of the incoming sample; its top bit marks out-of-range samples
  assign idx = cnt[AWIDTH-1:0];

  always_comb begin
    nxt_best_val = best_val;
    nxt_best_idx = best_idx;
    nxt_sec_val  = sec_val;
    nxt_sec_idx  = sec_idx;
    nxt_sec_vld  = sec_vld;
    nxt_cnt      = cnt;
    nxt_ovf      = ovf;
    if (din_tvalid) begin
      if (!cnt[AWIDTH]) begin
        if (cnt == '0) begin
          nxt_best_val = din;
          nxt_best_idx = idx;
          nxt_sec_vld  = 1'b0;
        end else if (better(din, best_val)) begin
          nxt_sec_val  = best_val;
          nxt_sec_idx  = best_idx;
          nxt_sec_vld  = 1'b1;
          nxt_best_val = din;
          nxt_best_idx = idx;
        end else if (!sec_vld || better(din, sec_val)) begin
          nxt_sec_val  = din;
          nxt_sec_idx  = idx;
          nxt_sec_vld  = 1'b1;
        end
      end else begin
        nxt_ovf = 1'b1;
      end
      if (cnt != CNT_MAX) nxt_cnt = cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      best_val          <= '0;
      best_idx          <= '0;
      sec_val           <= '0;
      sec_idx           <= '0;
      sec_vld           <= 1'b0;
      cnt               <= '0;
      ovf               <= 1'b0;
      dout_value        <= '0;
      dout              <= '0;
      dout_second       <= '0;
      dout_second_valid <= 1'b0;
      dout_count        <= '0;
      dout_ovf          <= 1'b0;
      dout_tvalid       <= 1'b0;
    end else begin
      dout_tvalid <= 1'b0;
      if (din_tvalid && din_tlast) begin
        dout_value        <= nxt_best_val;
        dout              <= nxt_best_idx;
        dout_second       <= nxt_sec_vld ? nxt_sec_idx : '0;
        dout_second_valid <= nxt_sec_vld;
        dout_count        <= nxt_cnt;
        dout_ovf          <= nxt_ovf;
        dout_tvalid       <= 1'b1;
        // clear in the tlast cycle so the next cycle can start a new frame
        best_val <= '0;
        best_idx <= '0;
        sec_val  <= '0;
        sec_idx  <= '0;
        sec_vld  <= 1'b0;
        cnt      <= '0;
        ovf      <= 1'b0;
      end else begin
        best_val <= nxt_best_val;
        best_idx <= nxt_best_idx;
        sec_val  <= nxt_sec_val;
        sec_idx  <= nxt_sec_idx;
        sec_vld  <= nxt_sec_vld;
        cnt      <= nxt_cnt;
        ovf      <= nxt_ovf;
      end
    end
  end

endmodule
